debug_uart_transmitter: RTL and testbench

- 8-bit UART transmitter for the MOPS-Hub debug serial link: 8N1 framing, LSB first, optional even parity.
- A small input FIFO lets firmware or debug logic queue several bytes back-to-back.
- Bit timing is derived from the system clock through `CLKS_PER_BIT`.
- It is the transmit end of `debug_uart_receiver`: both share the same `CLKS_PER_BIT` value, and the TX line can be looped back to that receiver's RX line.

---
 rtl/debug_uart_pkg.sv | 20 ++
 rtl/debug_uart_tx_fifo.sv | 62 ++++++
 rtl/debug_uart_transmitter.sv | 159 +++++++++++++++
 tb/tb_debug_uart_transmitter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_uart_pkg.sv
// Shared definitions for the debug UART transmit/receive pair.
package debug_uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam logic        IDLE_LINE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_START   = 3'b001,
    ST_DATA    = 3'b010,
    ST_STOP    = 3'b011,
    ST_CLEANUP = 3'b100,
    ST_PARITY  = 3'b101
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/debug_uart_tx_fifo.sv
// Single-clock byte FIFO queueing transmit data; cleared by synchronous reset.
module debug_uart_tx_fifo
  import debug_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Push,
  input  logic             i_Pop,
  input  logic [WIDTH-1:0] i_Data,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Full,
  output logic             o_Empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign o_Full  = (count_q == CW'(DEPTH));
  assign o_Empty = (count_q == '0);
  assign o_Data  = mem_q[rd_ptr_q];

  // Full rejects a push even if a pop frees a slot on the same edge.
  assign push_ok = i_Push && !o_Full;
  assign pop_ok  = i_Pop && !o_Empty;

  always_ff @(posedge i_Clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= i_Data;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/debug_uart_transmitter.sv
// 8N1 debug UART transmitter with input FIFO, LSB first.
// Optional even parity bit when DEBUG_UART_TX_PARITY_EN is defined.
module debug_uart_transmitter
  import debug_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Tx_DV,
  input  logic [DATA_W-1:0] i_Tx_Byte,
  output logic              o_Tx_Ready,
  output logic              o_Tx_Serial,
  output logic              o_Tx_Active,
  output logic              o_Tx_Done
);

  localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q;
  logic [CNT_W-1:0]  clk_cnt_q;
  logic [2:0]        bit_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              serial_q;
  logic              active_q;
  logic              done_q;
`ifdef DEBUG_UART_TX_PARITY_EN
  logic              parity_q;
`endif

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              bit_last;

  debug_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Push  (i_Tx_DV),
    .i_Pop   (fifo_pop),
    .i_Data  (i_Tx_Byte),
    .o_Data  (fifo_rdata),
    .o_Full  (fifo_full),
    .o_Empty (fifo_empty)
  );

  assign fifo_pop    = (state_q == ST_IDLE) && !fifo_empty;
  assign bit_last    = (clk_cnt_q == CNT_LAST);
  assign o_Tx_Ready  = !fifo_full;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= IDLE_LINE;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef DEBUG_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          serial_q  <= IDLE_LINE;
          active_q  <= 1'b0;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (!fifo_empty) begin
            shift_q <= fifo_rdata;
`ifdef DEBUG_UART_TX_PARITY_EN
            parity_q <= even_parity(fifo_rdata);
`endif
            state_q <= ST_START;
          end
        end

        ST_START: begin
          serial_q <= 1'b0;
          active_q <= 1'b1;
          if (bit_last) begin
            clk_cnt_q <= '0;
            state_q   <= ST_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

        ST_DATA: begin
          serial_q <= shift_q[bit_idx_q];
          if (bit_last) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
`ifdef DEBUG_UART_TX_PARITY_EN
              state_q   <= ST_PARITY;
`else
              state_q   <= ST_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

`ifdef DEBUG_UART_TX_PARITY_EN
        ST_PARITY: begin
          serial_q <= parity_q;
          if (bit_last) begin
            clk_cnt_q <= '0;
            state_q   <= ST_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
`endif

        ST_STOP: begin
          serial_q <= IDLE_LINE;
          if (bit_last) begin
            clk_cnt_q <= '0;
            state_q   <= ST_CLEANUP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

        ST_CLEANUP: begin
          serial_q <= IDLE_LINE;
          active_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= ST_IDLE;
        end

        default: begin
          serial_q  <= IDLE_LINE;
          active_q  <= 1'b0;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_uart_transmitter.sv
// Directed bench for debug_uart_transmitter at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_debug_uart_transmitter;

  localparam int CPB = 4;
  localparam int FD  = 4;
`ifdef DEBUG_UART_TX_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [7:0] tx_byte;
  logic       ready;
  logic       serial;
  logic       active;
  logic       done;

  int checks   = 0;
  int failures = 0;

  int         cap_n;
  int         done_cnt;
  int         ready_low;
  int         cap_start  [16];
  int         cap_done_t [16];
  logic [7:0] cap_byte   [16];
  logic       cap_par    [16];
  logic       cap_sbit   [16];
  logic       cap_pbit   [16];

  debug_uart_transmitter #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (FD)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Tx_DV     (dv),
    .i_Tx_Byte   (tx_byte),
    .o_Tx_Ready  (ready),
    .o_Tx_Serial (serial),
    .o_Tx_Active (active),
    .o_Tx_Done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line observer acting as the far-end receiver; it only records, tests compare.
  task automatic capture(input int cycles);
    int         pos;
    int         idx;
    bit         inframe;
    logic [7:0] b;
    logic       par;
    logic       sb;
    cap_n = 0; done_cnt = 0; ready_low = 0;
    inframe = 0; pos = 0; b = '0; par = 1'b0; sb = 1'b1;
    for (int t = 0; t < cycles; t++) begin
      tick();
      if (done) begin
        if (done_cnt < 16) cap_done_t[done_cnt] = t;
        done_cnt++;
      end
      if (!ready) ready_low++;
      if (!inframe) begin
        if (serial == 1'b0) begin
          inframe = 1;
          pos = 0;
          if (cap_n < 16) cap_start[cap_n] = t;
        end
      end else begin
        pos++;
      end
      if (inframe && (pos % CPB) == 2) begin
        idx = pos / CPB;
        if (idx == 0) sb = serial;
        else if (idx <= 8) b[idx-1] = serial;
        else if (idx < NB - 1) par = serial;
        if (idx == NB - 1) begin
          if (cap_n < 16) begin
            cap_byte[cap_n] = b;
            cap_par[cap_n]  = par;
            cap_sbit[cap_n] = sb;
            cap_pbit[cap_n] = serial;
          end
          cap_n++;
          inframe = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dv = 1'b0; tx_byte = '0;
    tick(); tick();
    checks++; if (serial !== 1'b1) begin failures++; $display("FAIL reset_serial got=%b exp=1", serial); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_loopback();
    logic [NB-1:0] exp_bits;
    logic [NB-1:0] rx_bits;
    logic [7:0]    b;
    logic          exp_s;
    logic          exp_a;
    logic          exp_d;
    int            dcount;
    b = 8'hA5;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef DEBUG_UART_TX_PARITY_EN
    exp_bits[9] = 1'b0;
`endif
    exp_bits[NB-1] = 1'b1;
    rx_bits = '1;
    dcount = 0;
    dv = 1'b1; tx_byte = b;
    tick();
    dv = 1'b0;
    for (int c = 1; c <= 2 + FRAME + 1; c++) begin
      tick();
      exp_s = (c >= 2 && c < 2 + FRAME) ? exp_bits[(c-2)/CPB] : 1'b1;
      exp_a = (c >= 2 && c < 2 + FRAME);
      exp_d = (c == 2 + FRAME);
      if (done) dcount++;
      if (c >= 2 && c < 2 + FRAME && ((c - 2) % CPB) == 2) rx_bits[(c-2)/CPB] = serial;
      checks++; if (serial !== exp_s) begin failures++; $display("FAIL loop_serial c=%0d got=%b exp=%b", c, serial, exp_s); end
      checks++; if (active !== exp_a) begin failures++; $display("FAIL loop_active c=%0d got=%b exp=%b", c, active, exp_a); end
      checks++; if (done !== exp_d) begin failures++; $display("FAIL loop_done c=%0d got=%b exp=%b", c, done, exp_d); end
    end
    checks++; if (rx_bits[8:1] !== 8'hA5) begin failures++; $display("FAIL loop_rx_byte got=%02h exp=a5", rx_bits[8:1]); end
    checks++; if (dcount != 1) begin failures++; $display("FAIL loop_done_count got=%0d exp=1", dcount); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    vals = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_write%0d got=%b exp=1", i, ready); end
          dv = 1'b1; tx_byte = vals[i];
          tick();
        end
        dv = 1'b0;
      end
      capture(4 * (FRAME + 2) + 20);
    join
    checks++; if (cap_n != 4) begin failures++; $display("FAIL b2b_frames got=%0d exp=4", cap_n); end
    checks++; if (done_cnt != 4) begin failures++; $display("FAIL b2b_done_count got=%0d exp=4", done_cnt); end
    checks++; if (ready_low != 0) begin failures++; $display("FAIL b2b_ready_low got=%0d exp=0", ready_low); end
    for (int k = 0; k < 4 && k < cap_n; k++) begin
      checks++; if (cap_byte[k] !== vals[k]) begin failures++; $display("FAIL b2b_byte%0d got=%02h exp=%02h", k, cap_byte[k], vals[k]); end
      checks++; if (cap_sbit[k] !== 1'b0 || cap_pbit[k] !== 1'b1) begin failures++; $display("FAIL b2b_framing%0d got=%b%b exp=01", k, cap_sbit[k], cap_pbit[k]); end
      if (k < done_cnt) begin
        checks++; if (cap_done_t[k] - cap_start[k] != FRAME) begin failures++; $display("FAIL b2b_len%0d got=%0d exp=%0d", k, cap_done_t[k] - cap_start[k], FRAME); end
      end
      if (k > 0) begin
        checks++;
        if (cap_start[k] - (cap_start[k-1] + (NB - 1) * CPB) != CPB + 2) begin
          failures++;
          $display("FAIL b2b_gap%0d got=%0d exp=%0d", k, cap_start[k] - (cap_start[k-1] + (NB - 1) * CPB), CPB + 2);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          dv = 1'b1; tx_byte = vals[i];
          tick();
        end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ovf_ready_full got=%b exp=0", ready); end
        tx_byte = 8'h99;
        tick(); tick(); tick();
        dv = 1'b0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ovf_ready_held got=%b exp=0", ready); end
      end
      capture(5 * (FRAME + 2) + 30);
    join
    checks++; if (cap_n != 5) begin failures++; $display("FAIL ovf_frames got=%0d exp=5", cap_n); end
    checks++; if (done_cnt != 5) begin failures++; $display("FAIL ovf_done_count got=%0d exp=5", done_cnt); end
    for (int k = 0; k < 5 && k < cap_n; k++) begin
      checks++; if (cap_byte[k] !== vals[k]) begin failures++; $display("FAIL ovf_byte%0d got=%02h exp=%02h", k, cap_byte[k], vals[k]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    dv = 1'b1; tx_byte = 8'hA5; tick();
    tx_byte = 8'hB1; tick();
    tx_byte = 8'hC2; tick();
    dv = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    checks++; if (serial !== 1'b0 || active !== 1'b1) begin failures++; $display("FAIL rmid_in_bit3 got=%b%b exp=01", serial, active); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (serial !== 1'b1) begin failures++; $display("FAIL rmid_serial got=%b exp=1", serial); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL rmid_active got=%b exp=0", active); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rmid_done got=%b exp=0", done); end
    capture(3 * (FRAME + 2));
    checks++; if (cap_n != 0) begin failures++; $display("FAIL rmid_frames got=%0d exp=0", cap_n); end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL rmid_done_count got=%0d exp=0", done_cnt); end
  endtask

  task automatic test_parity();
    fork
      begin
        dv = 1'b1; tx_byte = 8'hA5; tick();
        tx_byte = 8'h07; tick();
        dv = 1'b0;
      end
      capture(2 * (FRAME + 2) + 20);
    join
    checks++; if (cap_n != 2) begin failures++; $display("FAIL par_frames got=%0d exp=2", cap_n); end
    checks++; if (cap_byte[0] !== 8'hA5) begin failures++; $display("FAIL par_byte0 got=%02h exp=a5", cap_byte[0]); end
    checks++; if (cap_byte[1] !== 8'h07) begin failures++; $display("FAIL par_byte1 got=%02h exp=07", cap_byte[1]); end
    checks++; if (done_cnt != 2) begin failures++; $display("FAIL par_done_count got=%0d exp=2", done_cnt); end
    checks++; if (cap_done_t[0] - cap_start[0] != FRAME) begin failures++; $display("FAIL par_len got=%0d exp=%0d", cap_done_t[0] - cap_start[0], FRAME); end
`ifdef DEBUG_UART_TX_PARITY_EN
    checks++; if (cap_par[0] !== 1'b0) begin failures++; $display("FAIL par_bit_a5 got=%b exp=0", cap_par[0]); end
    checks++; if (cap_par[1] !== 1'b1) begin failures++; $display("FAIL par_bit_07 got=%b exp=1", cap_par[1]); end
`endif
  endtask

  task automatic test_idle();
    int bad_serial;
    int bad_active;
    int pulses;
    bad_serial = 0; bad_active = 0; pulses = 0;
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (serial !== 1'b1) bad_serial++;
      if (active !== 1'b0) bad_active++;
      if (done !== 1'b0) pulses++;
    end
    checks++; if (bad_serial != 0) begin failures++; $display("FAIL idle_serial low_cycles=%0d exp=0", bad_serial); end
    checks++; if (bad_active != 0) begin failures++; $display("FAIL idle_active active_cycles=%0d exp=0", bad_active); end
    checks++; if (pulses != 0) begin failures++; $display("FAIL idle_done pulses=%0d exp=0", pulses); end
  endtask

  initial begin
    rst = 1'b1; dv = 1'b0; tx_byte = '0;
    test_reset();
    test_loopback();
    tick(); tick();
    test_back_to_back();
    tick(); tick();
    test_overflow();
    tick(); tick();
    test_reset_mid_frame();
    tick(); tick();
    test_parity();
    tick(); tick();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
